// File: rtl/exc_sched_if.sv
// M-stage, CP0 and redirect signals seen by the exception sequencer.
// The slave modport is the sequencer's view; master is the environment's view.
interface exc_sched_if;
  logic        M_Valid;
  logic [31:0] M_VPC;
  logic        M_BD;
  logic [4:0]  M_ExcCode;
  logic        M_Eret;
  logic        M_Mtc0;
  logic [4:0]  M_CP0Add;
  logic [31:0] M_CP0Data;
  logic [5:0]  HWIntRaw;
  logic        CP0_Req;
  logic [31:0] CP0_EPC;
  logic        CP0_en;
  logic [4:0]  CP0_Add;
  logic [31:0] CP0_In;
  logic [31:0] CP0_VPC;
  logic        CP0_BD;
  logic [4:0]  CP0_ExcCode;
  logic [5:0]  CP0_HWInt;
  logic        CP0_EXLClr;
  logic        Flush;
  logic        NPCSel;
  logic [31:0] NPCTarget;
  logic        Draining;
  logic [15:0] ExcCount;

  modport slave (
    input  M_Valid, M_VPC, M_BD, M_ExcCode, M_Eret, M_Mtc0, M_CP0Add, M_CP0Data,
           HWIntRaw, CP0_Req, CP0_EPC,
    output CP0_en, CP0_Add, CP0_In, CP0_VPC, CP0_BD, CP0_ExcCode, CP0_HWInt,
           CP0_EXLClr, Flush, NPCSel, NPCTarget, Draining, ExcCount
  );

  modport master (
    output M_Valid, M_VPC, M_BD, M_ExcCode, M_Eret, M_Mtc0, M_CP0Add, M_CP0Data,
           HWIntRaw, CP0_Req, CP0_EPC,
    input  CP0_en, CP0_Add, CP0_In, CP0_VPC, CP0_BD, CP0_ExcCode, CP0_HWInt,
           CP0_EXLClr, Flush, NPCSel, NPCTarget, Draining, ExcCount
  );
endinterface

// File: rtl/exc_sched.sv
// Exception/interrupt sequencer between the M stage and CP0: drives CP0 writes,
// flush and PC redirect, then masks stale M-stage inputs while the pipe drains.
module exc_sched #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic        clk,
  input logic        reset,
  exc_sched_if.slave bus
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned XCW   = 16;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      last_vpc_q;
  logic             last_bd_q;
  logic [5:0]       hwint_q;
  logic [XCW-1:0]   exc_count_q;

  logic run_c, valid_c, req_c, exlclr_c, flush_c;

  // Next state and all same-cycle outputs; M inputs count as a bubble in DRAIN.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    run_c          = (state_q == RUN);
    valid_c        = run_c & bus.M_Valid;
    req_c          = run_c & bus.CP0_Req;
    exlclr_c       = valid_c & bus.M_Eret & ~req_c;
    flush_c        = req_c | exlclr_c;

    bus.CP0_en      = valid_c & bus.M_Mtc0 & ~req_c;
    bus.CP0_Add     = run_c ? bus.M_CP0Add : 5'd0;
    bus.CP0_In      = run_c ? bus.M_CP0Data : 32'd0;
    bus.CP0_VPC     = valid_c ? bus.M_VPC : last_vpc_q;
    bus.CP0_BD      = valid_c ? bus.M_BD : last_bd_q;
    bus.CP0_ExcCode = valid_c ? bus.M_ExcCode : 5'd0;
    bus.CP0_HWInt   = run_c ? hwint_q : 6'd0;
    bus.CP0_EXLClr  = exlclr_c;
    bus.Flush       = flush_c;
    bus.NPCSel      = flush_c;
    bus.NPCTarget   = 32'd0;
    bus.Draining    = ~run_c;
    bus.ExcCount    = exc_count_q;

    if (req_c) begin
      bus.NPCTarget = HANDLER_ADDR;
    end else if (exlclr_c) begin
      bus.NPCTarget = bus.CP0_EPC;
    end

    case (state_q)
      RUN: begin
        if (flush_c) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      last_vpc_q  <= RESET_PC;
      last_bd_q   <= 1'b0;
      hwint_q     <= 6'd0;
      exc_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hwint_q <= bus.HWIntRaw;
      if (valid_c) begin
        last_vpc_q <= bus.M_VPC;
        last_bd_q  <= bus.M_BD;
      end
      // Saturating count of taken exceptions/interrupts.
      if (req_c && (exc_count_q != {XCW{1'b1}})) begin
        exc_count_q <= exc_count_q + XCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_exc_sched.sv
// Scoreboard bench for exc_sched: a driver pushes model expectations per cycle,
// a monitor pops and compares them against the sampled DUT outputs.
module tb_exc_sched;

  logic clk;
  logic reset;
  exc_sched_if bus ();

  exc_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic        eret;
    logic        mtc0;
    logic [4:0]  add;
    logic [31:0] data;
    logic [5:0]  hw;
    logic        req;
    logic [31:0] epc;
  } stim_t;

  typedef struct {
    logic        en;
    logic [4:0]  add;
    logic [31:0] din;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hwint;
    logic        exl;
    logic        flush;
    logic        npcsel;
    logic [31:0] target;
    logic        draining;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: remaining masked cycles, last real PC/BD, interrupt sample, count.
  int          m_drain_left;
  logic [31:0] m_last_vpc;
  logic        m_last_bd;
  logic [5:0]  m_hw;
  int          m_cnt;

  function automatic exp_t model_expect(input stim_t s);
    exp_t e;
    bit running, live, take;
    running  = (m_drain_left == 0);
    live     = running && s.valid;
    take     = running && s.req;
    e.en     = live && s.mtc0 && !take;
    e.add    = running ? s.add : 5'd0;
    e.din    = running ? s.data : 32'd0;
    e.vpc    = live ? s.vpc : m_last_vpc;
    e.bd     = live ? s.bd : m_last_bd;
    e.exc    = live ? s.exc : 5'd0;
    e.hwint  = running ? m_hw : 6'd0;
    e.exl    = live && s.eret && !take;
    e.flush  = take || e.exl;
    e.npcsel = e.flush;
    e.target = take ? 32'h0000_4180 : (e.exl ? s.epc : 32'd0);
    e.draining = !running;
    e.cnt    = 16'(m_cnt);
    return e;
  endfunction

  task automatic model_update(input stim_t s, input exp_t e);
    if (s.rst) begin
      m_drain_left = 0;
      m_last_vpc   = 32'h0000_3000;
      m_last_bd    = 1'b0;
      m_hw         = 6'd0;
      m_cnt        = 0;
    end else begin
      m_hw = s.hw;
      if (m_drain_left == 0) begin
        if (s.valid) begin
          m_last_vpc = s.vpc;
          m_last_bd  = s.bd;
        end
        if (s.req && m_cnt < 65535) m_cnt = m_cnt + 1;
        if (e.flush) m_drain_left = 3;
      end else begin
        m_drain_left = m_drain_left - 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks = n_checks + 1;
    if (act !== expv) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.rst   = ($urandom_range(63) == 0);
    s.valid = ($urandom_range(9) < 7);
    s.vpc   = {16'h0000, 14'($urandom), 2'b00};
    s.bd    = 1'($urandom);
    s.exc   = ($urandom_range(4) == 0) ? 5'($urandom) : 5'd0;
    s.eret  = ($urandom_range(9) == 0);
    s.mtc0  = ($urandom_range(4) == 0);
    s.add   = 5'($urandom);
    s.data  = 32'($urandom);
    s.hw    = 6'($urandom);
    s.req   = ($urandom_range(6) == 0);
    s.epc   = {16'h0000, 14'($urandom), 2'b00};
    return s;
  endfunction

  task automatic run_cycle(input stim_t s);
    exp_t e;
    @(negedge clk);
    reset         = s.rst;
    bus.M_Valid   = s.valid;
    bus.M_VPC     = s.vpc;
    bus.M_BD      = s.bd;
    bus.M_ExcCode = s.exc;
    bus.M_Eret    = s.eret;
    bus.M_Mtc0    = s.mtc0;
    bus.M_CP0Add  = s.add;
    bus.M_CP0Data = s.data;
    bus.HWIntRaw  = s.hw;
    bus.CP0_Req   = s.req;
    bus.CP0_EPC   = s.epc;
    e = model_expect(s);
    exp_q.push_back(e);
    model_update(s, e);
  endtask

  // Monitor: compares every cycle that has a pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("CP0_en",      32'(bus.CP0_en),      32'(e.en));
        chk("CP0_Add",     32'(bus.CP0_Add),     32'(e.add));
        chk("CP0_In",      bus.CP0_In,           e.din);
        chk("CP0_VPC",     bus.CP0_VPC,          e.vpc);
        chk("CP0_BD",      32'(bus.CP0_BD),      32'(e.bd));
        chk("CP0_ExcCode", 32'(bus.CP0_ExcCode), 32'(e.exc));
        chk("CP0_HWInt",   32'(bus.CP0_HWInt),   32'(e.hwint));
        chk("CP0_EXLClr",  32'(bus.CP0_EXLClr),  32'(e.exl));
        chk("Flush",       32'(bus.Flush),       32'(e.flush));
        chk("NPCSel",      32'(bus.NPCSel),      32'(e.npcsel));
        chk("NPCTarget",   bus.NPCTarget,        e.target);
        chk("Draining",    32'(bus.Draining),    32'(e.draining));
        chk("ExcCount",    32'(bus.ExcCount),    32'(e.cnt));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    bus.M_Valid = 1'b0; bus.M_VPC = '0; bus.M_BD = 1'b0; bus.M_ExcCode = '0;
    bus.M_Eret = 1'b0; bus.M_Mtc0 = 1'b0; bus.M_CP0Add = '0; bus.M_CP0Data = '0;
    bus.HWIntRaw = '0; bus.CP0_Req = 1'b0; bus.CP0_EPC = '0;
    m_drain_left = 0; m_last_vpc = 32'h3000; m_last_bd = 1'b0; m_hw = '0; m_cnt = 0;
    repeat (2) @(posedge clk);

    // Reset then idle.
    s = idle(); s.rst = 1'b1;
    run_cycle(s);
    repeat (5) run_cycle(idle());
    #2;
    chk("t1_flush", 32'(bus.Flush), 32'd0);
    chk("t1_vpc", bus.CP0_VPC, 32'h0000_3000);
    chk("t1_count", 32'(bus.ExcCount), 32'd0);

    // Exception on a real instruction.
    s = idle(); s.valid = 1'b1; s.vpc = 32'h3010; s.exc = 5'd4; s.req = 1'b1;
    run_cycle(s);
    #2;
    chk("t2_flush", 32'(bus.Flush), 32'd1);
    chk("t2_target", bus.NPCTarget, 32'h0000_4180);
    chk("t2_en", 32'(bus.CP0_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      run_cycle(idle());
      #2;
      chk("t2_draining", 32'(bus.Draining), 32'd1);
    end
    run_cycle(idle());
    #2;
    chk("t2_drain_end", 32'(bus.Draining), 32'd0);
    chk("t2_count", 32'(bus.ExcCount), 32'd1);

    // eret, held stale during the drain.
    s = idle(); s.valid = 1'b1; s.eret = 1'b1; s.epc = 32'h3010;
    run_cycle(s);
    #2;
    chk("t3_exlclr", 32'(bus.CP0_EXLClr), 32'd1);
    chk("t3_target", bus.NPCTarget, 32'h0000_3010);
    for (int i = 0; i < 3; i++) run_cycle(s);

    // Bubble reports last real PC/BD; interrupt lines one cycle late.
    s = idle(); s.valid = 1'b1; s.vpc = 32'h3020; s.bd = 1'b1; s.hw = 6'b000100;
    run_cycle(s);
    s.valid = 1'b0; s.vpc = 32'h0; s.bd = 1'b0;
    run_cycle(s);
    #2;
    chk("t4_hwint", 32'(bus.CP0_HWInt), 32'h4);
    chk("t4_vpc", bus.CP0_VPC, 32'h0000_3020);
    chk("t4_bd", 32'(bus.CP0_BD), 32'd1);

    // mtc0 with and without a concurrent request.
    s = idle(); s.valid = 1'b1; s.mtc0 = 1'b1; s.add = 5'd12; s.data = 32'h0000_fc01;
    run_cycle(s);
    #2;
    chk("t5_en", 32'(bus.CP0_en), 32'd1);
    chk("t5_in", bus.CP0_In, 32'h0000_fc01);
    s.req = 1'b1;
    run_cycle(s);
    #2;
    chk("t5_en_req", 32'(bus.CP0_en), 32'd0);
    chk("t5_flush_req", 32'(bus.Flush), 32'd1);
    repeat (3) run_cycle(idle());

    // Request and eret together; then reset in the middle of the drain.
    s = idle(); s.valid = 1'b1; s.eret = 1'b1; s.req = 1'b1; s.epc = 32'h5550;
    run_cycle(s);
    #2;
    chk("t6_exlclr", 32'(bus.CP0_EXLClr), 32'd0);
    chk("t6_target", bus.NPCTarget, 32'h0000_4180);
    run_cycle(idle());
    s = idle(); s.rst = 1'b1;
    run_cycle(s);
    run_cycle(idle());
    #2;
    chk("t6_reset_drain", 32'(bus.Draining), 32'd0);

    // Saturation: preload the counter at its ceiling, then take a request.
    run_cycle(idle());
    #3;
    force dut.exc_count_q = 16'hFFFF;
    #1;
    release dut.exc_count_q;
    m_cnt = 65535;
    s = idle(); s.req = 1'b1;
    run_cycle(s);
    repeat (4) run_cycle(idle());
    #2;
    chk("t6_saturate", 32'(bus.ExcCount), 32'h0000_FFFF);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) run_cycle(rnd_stim());
    run_cycle(idle());

    @(negedge clk);
    #3;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
